// File: rtl/regbank_arbiter.sv
// rtl/regbank_arbiter.sv - round-robin arbiter sequencing single accesses into a shared register bank
// Optional locked bursts enabled by defining REGBANK_ARBITER_LOCK_EN.
module regbank_arbiter #(
    parameter int NREQ     = 4,
    parameter int W        = 8,
    parameter int AW       = 3,
    parameter int DEPTH    = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic               clk,
    input  logic               notreset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*W-1:0]  wdata,
`ifdef REGBANK_ARBITER_LOCK_EN
    input  logic [NREQ-1:0]    lock,
`endif
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [W-1:0]       rdata,
    output logic               busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t          r_state;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_ack;
    logic [W-1:0]    r_rdata;
    logic            r_busy;
    logic [IW-1:0]   r_last;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [W-1:0]    r_wdata;
    logic [W-1:0]    r_bank [DEPTH];
`ifdef REGBANK_ARBITER_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);
    logic [CW-1:0]   r_lock_cnt;
    logic            w_relock;
`endif

    logic            w_found;
    logic [IW-1:0]   w_win;
    logic            w_in_range;

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req[(int'(r_last) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = IW'((int'(r_last) + k) % NREQ);
            end
        end
    end

    assign w_in_range = (int'(r_addr) < DEPTH);

`ifdef REGBANK_ARBITER_LOCK_EN
    assign w_relock = lock[r_last] && (int'(r_lock_cnt) < MAX_LOCK - 1);
`endif

    always_ff @(posedge clk or negedge notreset) begin
        if (!notreset) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_rdata <= '0;
            r_busy  <= 1'b0;
            r_last  <= IW'(NREQ - 1);
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
`ifdef REGBANK_ARBITER_LOCK_EN
            r_lock_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= NREQ'(1) << w_win;
                        r_last  <= w_win;
                        r_we    <= we[w_win];
                        r_addr  <= addr[w_win*AW +: AW];
                        r_wdata <= wdata[w_win*W +: W];
                        r_busy  <= 1'b1;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_we) begin
                        if (w_in_range) r_bank[r_addr] <= r_wdata;
                    end else begin
                        r_rdata <= w_in_range ? r_bank[r_addr] : '0;
                    end
                    r_ack   <= r_gnt;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_ack   <= '0;
                    r_rdata <= '0;
`ifdef REGBANK_ARBITER_LOCK_EN
                    if (w_relock) begin
                        r_we       <= we[r_last];
                        r_addr     <= addr[r_last*AW +: AW];
                        r_wdata    <= wdata[r_last*W +: W];
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                        r_state    <= S_ACCESS;
                    end else begin
                        r_lock_cnt <= '0;
                        r_gnt      <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
`else
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt   = r_gnt;
    assign ack   = r_ack;
    assign rdata = r_rdata;
    assign busy  = r_busy;
endmodule

// File: tb/tb_regbank_arbiter.sv
// tb/tb_regbank_arbiter.sv - directed-vector bench for regbank_arbiter
module tb_regbank_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int AW   = 3;

    logic               clk = 1'b0;
    logic               notreset;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*W-1:0]  wdata;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [W-1:0]       rdata;
    logic               busy;

    int vectors     = 0;
    int miscompares = 0;

    regbank_arbiter #(.NREQ(NREQ), .W(W), .AW(AW), .DEPTH(6), .MAX_LOCK(4)) dut (
        .clk      (clk),
        .notreset (notreset),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
`ifdef REGBANK_ARBITER_LOCK_EN
        .lock     (lock),
`endif
        .gnt      (gnt),
        .ack      (ack),
        .rdata    (rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
        req[i]           = 1'b1;
        we[i]            = w;
        addr[i*AW +: AW] = a;
        wdata[i*W +: W]  = d;
    endtask

    // One complete access: grant, ack (with read data), then idle.
    task automatic do_access(input string tag, input int i, input logic w, input logic [AW-1:0] a,
                             input logic [W-1:0] d, input logic [W-1:0] exp_rd);
        set_req(i, w, a, d);
        tick();
        check_val({tag, "_gnt"}, 32'(gnt), 32'(1 << i));
        req = '0;
        tick();
        check_val({tag, "_ack"}, 32'(ack), 32'(1 << i));
        if (!w) check_val({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
        tick();
        check_val({tag, "_ack_off"}, 32'(ack), 32'h0);
        check_val({tag, "_rdata_off"}, 32'(rdata), 32'h0);
        check_val({tag, "_idle"}, 32'(busy), 32'h0);
    endtask

    initial begin
        notreset = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0; lock = '0;
        #23;
        check_val("rst_gnt", 32'(gnt), 32'h0);
        check_val("rst_ack", 32'(ack), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_rdata", 32'(rdata), 32'h0);
        notreset = 1'b1;
        tick();

        do_access("wr_a5", 0, 1'b1, 3'd3, 8'hA5, 8'h00);
        do_access("rd_a5", 1, 1'b0, 3'd3, 8'h00, 8'hA5);
        do_access("wr_3c", 2, 1'b1, 3'd5, 8'h3C, 8'h00);
        do_access("wr_oor", 2, 1'b1, 3'd7, 8'hFF, 8'h00);
        do_access("rd_oor7", 3, 1'b0, 3'd7, 8'h00, 8'h00);
        do_access("rd_oor6", 0, 1'b0, 3'd6, 8'h00, 8'h00);
        do_access("rd_5", 1, 1'b0, 3'd5, 8'h00, 8'h3C);

        // Reset during the ACCESS cycle of a write.
        set_req(0, 1'b1, 3'd1, 8'h77);
        tick();
        check_val("mid_gnt", 32'(gnt), 32'h1);
        req = '0;
        #2 notreset = 1'b0;
        #1;
        check_val("mid_rst_gnt", 32'(gnt), 32'h0);
        check_val("mid_rst_busy", 32'(busy), 32'h0);
        tick();
        check_val("mid_rst_ack", 32'(ack), 32'h0);
        notreset = 1'b1;
        tick();
        check_val("post_rst_ack", 32'(ack), 32'h0);
        do_access("rd_cleared1", 1, 1'b0, 3'd1, 8'h00, 8'h00);
        do_access("rd_cleared3", 2, 1'b0, 3'd3, 8'h00, 8'h00);
        do_access("rd_cleared5", 3, 1'b0, 3'd5, 8'h00, 8'h00);

        // All requesters held high: round robin 0,1,2,3,0 from a fresh reset.
        notreset = 1'b0;
        #3 notreset = 1'b1;
        we = '0;
        addr = '0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check_val($sformatf("rr_gnt%0d", g), 32'(gnt), 32'(1 << (g % 4)));
            tick();
            check_val($sformatf("rr_ack%0d", g), 32'(ack), 32'(1 << (g % 4)));
            tick();
            check_val($sformatf("rr_ackoff%0d", g), 32'(ack), 32'h0);
        end
        req = '0;
        tick();
        check_val("rr_idle", 32'(busy), 32'h0);

`ifdef REGBANK_ARBITER_LOCK_EN
        // Locked burst: four back-to-back accesses for requester 0, then requester 1.
        notreset = 1'b0;
        #3 notreset = 1'b1;
        set_req(0, 1'b1, 3'd2, 8'h11);
        set_req(1, 1'b0, 3'd2, 8'h00);
        lock = 4'b0001;
        tick();
        check_val("lk_gnt", 32'(gnt), 32'h1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val($sformatf("lk_ack%0d", k), 32'(ack), 32'h1);
            tick();
            check_val($sformatf("lk_ackoff%0d", k), 32'(ack), 32'h0);
            check_val($sformatf("lk_gnthold%0d", k), 32'(gnt), (k < 3) ? 32'h1 : 32'h0);
        end
        tick();
        check_val("lk_next_gnt", 32'(gnt), 32'h2);
        req = '0;
        lock = '0;
        tick();
        check_val("lk_next_ack", 32'(ack), 32'h2);
        check_val("lk_next_rdata", 32'(rdata), 32'h11);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
